// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - shared widths and ALU operation encodings
// Exports: XLEN, ALU_OP_WIDTH, ROB_SIZE_WIDTH, ALU_ADD..ALU_GEU opcodes.
package alu_unit_pkg;

  localparam int XLEN           = 32;
  localparam int ALU_OP_WIDTH   = 4;
  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHR  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHRA = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NEQ  = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LT   = 4'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 4'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 4'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 4'd13;

endpackage

// File: rtl/alu_unit_result_fifo.sv
// rtl/alu_unit_result_fifo.sv - result FIFO holding {res, id} between EX and the result bus
// Ports: clk, rst (sync active-high), clear (flush), push/push_data,
//        pop, head (combinational head entry), count (occupancy, DEPTH inclusive).
// Callers guard push against full (allowing a same-cycle pop) and pop against empty.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered ALU execute stage with result FIFO and result-bus output registers
// Ports: clk, rst (sync active-high), flush; issue side rs_ready/rs_op/rs_val1/rs_val2/rs_id;
//        cdb_grant; outputs alu_full (combinational backpressure), alu_ready/alu_res/alu_id
//        (registered broadcast), alu_overflow (sticky dropped-issue flag).
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int RES_FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      rs_ready,
  input  logic [ALU_OP_WIDTH-1:0]   rs_op,
  input  logic [XLEN-1:0]           rs_val1,
  input  logic [XLEN-1:0]           rs_val2,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_id,
  input  logic                      cdb_grant,
  output logic                      alu_full,
  output logic                      alu_ready,
  output logic [XLEN-1:0]           alu_res,
  output logic [ROB_SIZE_WIDTH-1:0] alu_id,
  output logic                      alu_overflow
);

  localparam int CW = $clog2(RES_FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int FW = XLEN + ROB_SIZE_WIDTH;

  logic                      ex_valid;
  logic [ALU_OP_WIDTH-1:0]   ex_op;
  logic [XLEN-1:0]           ex_v1;
  logic [XLEN-1:0]           ex_v2;
  logic [ROB_SIZE_WIDTH-1:0] ex_id;
  logic [XLEN-1:0]           ex_result;

  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_pop;
  logic          ex_bypass;
  logic          ex_push;
  logic          ex_free;
  logic          ex_capture;
  logic [OW-1:0] occupancy;
  logic [4:0]    shamt;

  assign shamt = ex_v2[4:0];

  always_comb begin
    ex_result = '0;
    case (ex_op)
      ALU_ADD:  ex_result = ex_v1 + ex_v2;
      ALU_SUB:  ex_result = ex_v1 - ex_v2;
      ALU_AND:  ex_result = ex_v1 & ex_v2;
      ALU_OR:   ex_result = ex_v1 | ex_v2;
      ALU_XOR:  ex_result = ex_v1 ^ ex_v2;
      ALU_SHL:  ex_result = ex_v1 << shamt;
      ALU_SHR:  ex_result = ex_v1 >> shamt;
      ALU_SHRA: ex_result = $unsigned($signed(ex_v1) >>> shamt);
      ALU_EQ:   ex_result = XLEN'(ex_v1 == ex_v2);
      ALU_NEQ:  ex_result = XLEN'(ex_v1 != ex_v2);
      ALU_LT:   ex_result = XLEN'($signed(ex_v1) < $signed(ex_v2));
      ALU_LTU:  ex_result = XLEN'(ex_v1 < ex_v2);
      ALU_GE:   ex_result = XLEN'($signed(ex_v1) >= $signed(ex_v2));
      ALU_GEU:  ex_result = XLEN'(ex_v1 >= ex_v2);
      default:  ex_result = '0;
    endcase
  end

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(RES_FIFO_DEPTH));

  // Queued results always go first so bus order matches issue order.
  assign fifo_pop   = !fifo_empty && cdb_grant;
  assign ex_bypass  = ex_valid && fifo_empty && cdb_grant;
  assign ex_push    = ex_valid && !ex_bypass && (!fifo_full || fifo_pop);
  assign ex_free    = !ex_valid || ex_bypass || ex_push;
  assign ex_capture = rs_ready && ex_free;

  // Counts the issue in flight this cycle since the issuer reacts one cycle late.
  assign occupancy = OW'(fifo_count) + OW'(ex_valid) + OW'(rs_ready);
  assign alu_full  = (occupancy >= OW'(RES_FIFO_DEPTH));

  result_fifo #(
    .DEPTH (RES_FIFO_DEPTH),
    .WIDTH (FW)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (ex_push),
    .push_data ({ex_result, ex_id}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_v1    <= '0;
      ex_v2    <= '0;
      ex_id    <= '0;
    end else if (ex_capture) begin
      ex_valid <= 1'b1;
      ex_op    <= rs_op;
      ex_v1    <= rs_val1;
      ex_v2    <= rs_val2;
      ex_id    <= rs_id;
    end else if (ex_bypass || ex_push) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ready <= 1'b0;
      alu_res   <= '0;
      alu_id    <= '0;
    end else if (flush) begin
      alu_ready <= 1'b0;
    end else if (fifo_pop) begin
      alu_ready <= 1'b1;
      alu_res   <= fifo_head[FW-1:ROB_SIZE_WIDTH];
      alu_id    <= fifo_head[ROB_SIZE_WIDTH-1:0];
    end else if (ex_bypass) begin
      alu_ready <= 1'b1;
      alu_res   <= ex_result;
      alu_id    <= ex_id;
    end else begin
      alu_ready <= 1'b0;
    end
  end

  // Sticky until reset; a flush does not hide a past protocol violation.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_overflow <= 1'b0;
    end else if (!flush && rs_ready && !ex_free) begin
      alu_overflow <= 1'b1;
    end
  end

endmodule
